// File: rtl/risc_sequencer_if.sv
// Bus between the instruction register / memory side and the VeriRisc sequencer.
// The master modport is the sequencer's view; slave is the surrounding datapath's view.
interface risc_sequencer_if #(
   parameter int OPCODE_W = 3
);
   logic                zero;
   logic [OPCODE_W-1:0] opcode;
   logic                mem_rdy;
   logic                resume;
   logic                sel;
   logic                rd;
   logic                ld_ir;
   logic                halt;
   logic                inc_pc;
   logic                ld_ac;
   logic                ld_pc;
   logic                wr;
   logic                data_e;
   logic [2:0]          phase;
   logic                halted;
   logic                illegal_op;
   logic                mem_err;

   modport master (
      input  zero, opcode, mem_rdy, resume,
      output sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e,
      output phase, halted, illegal_op, mem_err
   );

   modport slave (
      output zero, opcode, mem_rdy, resume,
      input  sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e,
      input  phase, halted, illegal_op, mem_err
   );
endinterface

// File: rtl/risc_sequencer.sv
// VeriRisc control unit: 8-phase instruction-cycle counter with memory stall handshake,
// stall watchdog, illegal-opcode trap and latched halt/resume, decoding the datapath strobes.
module risc_sequencer #(
   parameter int OPCODE_W = 3,
   parameter int TIMEOUT  = 15
) (
   input  logic             clk,
   input  logic             rst_,
   risc_sequencer_if.master bus
);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   typedef enum logic [2:0] {
      PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7
   } phase_e;

   phase_e           phase_q, phase_d;
   logic             halted_q, halted_d;
   logic             illegal_op_q, illegal_op_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] wait_inc;

   logic [2:0] op_lo;
   logic       ill;
   logic       is_hlt, is_skz, is_alu, is_sto, is_jmp;
   logic       stall_ph, trap;

   assign op_lo  = bus.opcode[2:0];
   assign is_hlt = (op_lo == OP_HLT);
   assign is_skz = (op_lo == OP_SKZ);
   assign is_alu = (op_lo == OP_ADD) || (op_lo == OP_AND) || (op_lo == OP_XOR) || (op_lo == OP_LDA);
   assign is_sto = (op_lo == OP_STO);
   assign is_jmp = (op_lo == OP_JMP);

   // Any set bit above the base 3-bit opcode field marks an instruction this core cannot execute.
   if (OPCODE_W > 3) begin : g_ill
      assign ill = |bus.opcode[OPCODE_W-1:3];
   end else begin : g_no_ill
      assign ill = 1'b0;
   end

   assign stall_ph = (phase_q == PH3) || ((phase_q == PH6) && is_alu) || ((phase_q == PH7) && is_sto);
   assign trap     = (phase_q == PH4) && (is_hlt || ill);
   assign wait_inc = wait_cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         phase_q      <= PH0;
         halted_q     <= 1'b0;
         illegal_op_q <= 1'b0;
         mem_err_q    <= 1'b0;
         wait_cnt_q   <= '0;
      end else begin
         phase_q      <= phase_d;
         halted_q     <= halted_d;
         illegal_op_q <= illegal_op_d;
         mem_err_q    <= mem_err_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   // A watchdog expiry resumes into a re-fetch; a phase-4 trap resumes just past the trap.
   always_comb begin
      phase_d      = phase_q;
      halted_d     = halted_q;
      illegal_op_d = illegal_op_q;
      mem_err_d    = mem_err_q;
      wait_cnt_d   = wait_cnt_q;
      if (halted_q) begin
         if (bus.resume) begin
            halted_d     = 1'b0;
            illegal_op_d = 1'b0;
            mem_err_d    = 1'b0;
            wait_cnt_d   = '0;
            phase_d      = mem_err_q ? PH0 : PH5;
         end
      end else if (trap) begin
         halted_d     = 1'b1;
         illegal_op_d = illegal_op_q | ill;
      end else if (stall_ph && !bus.mem_rdy) begin
         if (TIMEOUT != 0) begin
            wait_cnt_d = wait_inc;
            if (wait_inc == CNT_W'(TIMEOUT)) begin
               mem_err_d = 1'b1;
               halted_d  = 1'b1;
            end
         end
      end else begin
         phase_d    = phase_e'(phase_q + 3'd1);
         wait_cnt_d = '0;
      end
   end

   always_comb begin
      bus.sel    = 1'b0;
      bus.rd     = 1'b0;
      bus.ld_ir  = 1'b0;
      bus.halt   = 1'b0;
      bus.inc_pc = 1'b0;
      bus.ld_ac  = 1'b0;
      bus.ld_pc  = 1'b0;
      bus.wr     = 1'b0;
      bus.data_e = 1'b0;
      if (halted_q) begin
         bus.halt = 1'b1;
      end else begin
         case (phase_q)
            PH0: bus.sel = 1'b1;
            PH1: begin
               bus.sel = 1'b1;
               bus.rd  = 1'b1;
            end
            PH2, PH3: begin
               bus.sel   = 1'b1;
               bus.rd    = 1'b1;
               bus.ld_ir = 1'b1;
            end
            PH4: begin
               bus.inc_pc = 1'b1;
               bus.halt   = is_hlt | ill;
            end
            PH5: bus.rd = is_alu;
            PH6: begin
               bus.rd     = is_alu;
               bus.inc_pc = is_skz & bus.zero;
               bus.ld_pc  = is_jmp;
               bus.data_e = is_sto;
            end
            PH7: begin
               bus.rd     = is_alu;
               bus.ld_ac  = is_alu;
               bus.ld_pc  = is_jmp;
               bus.wr     = is_sto;
               bus.data_e = is_sto;
            end
            default: ;
         endcase
      end
   end

   assign bus.phase      = phase_q;
   assign bus.halted     = halted_q;
   assign bus.illegal_op = illegal_op_q;
   assign bus.mem_err    = mem_err_q;
endmodule

// File: tb/tb_risc_sequencer.sv
// Self-checking bench for risc_sequencer: directed instruction scenarios followed by randomized
// traffic, every cycle compared against a cycle-level model of the instruction-cycle rules.
module tb_risc_sequencer;
   localparam int OPCODE_W = 4;
   localparam int TIMEOUT  = 15;

   logic clk = 1'b0;
   logic rst_;

   risc_sequencer_if #(.OPCODE_W(OPCODE_W)) bus ();

   risc_sequencer #(
      .OPCODE_W(OPCODE_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst_(rst_),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total_checks  = 0;
   int passed_checks = 0;

   int   m_phase;
   bit   m_halted, m_ill, m_err;
   int   m_wait;

   logic [3:0] cur_op;
   logic       cur_zero, cur_rdy, cur_resume;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_checks++;
      if (got === exp) passed_checks++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Expected {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e} from the instruction-cycle table.
   function automatic logic [8:0] exp_strobes(input int ph, input bit frozen, input logic [3:0] op, input logic z);
      int code;
      bit ill, alu;
      bit sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
      code = int'(op[2:0]);
      ill  = (op[3] != 1'b0);
      alu  = (code >= 2) && (code <= 5);
      {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e} = 9'b0;
      if (frozen) halt = 1'b1;
      else begin
         case (ph)
            0: sel = 1'b1;
            1: begin sel = 1'b1; rd = 1'b1; end
            2, 3: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
            4: begin inc_pc = 1'b1; halt = (code == 0) || ill; end
            5: rd = alu;
            6: begin rd = alu; inc_pc = (code == 1) && z; ld_pc = (code == 7); data_e = (code == 6); end
            7: begin rd = alu; ld_ac = alu; ld_pc = (code == 7); wr = (code == 6); data_e = (code == 6); end
            default: ;
         endcase
      end
      return {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};
   endfunction

   function automatic bit is_stall(input int ph, input logic [3:0] op);
      int code;
      code = int'(op[2:0]);
      return (ph == 3) || ((ph == 6) && (code >= 2) && (code <= 5)) || ((ph == 7) && (code == 6));
   endfunction

   task automatic model_step();
      if (m_halted) begin
         if (cur_resume) begin
            m_phase  = m_err ? 0 : 5;
            m_halted = 0;
            m_ill    = 0;
            m_err    = 0;
            m_wait   = 0;
         end
      end else if ((m_phase == 4) && ((cur_op[2:0] == 3'd0) || cur_op[3])) begin
         m_halted = 1;
         if (cur_op[3]) m_ill = 1;
      end else if (is_stall(m_phase, cur_op) && !cur_rdy) begin
         m_wait++;
         if ((TIMEOUT != 0) && (m_wait == TIMEOUT)) begin
            m_err    = 1;
            m_halted = 1;
         end
      end else begin
         m_phase = (m_phase + 1) % 8;
         m_wait  = 0;
      end
   endtask

   task automatic compare_all();
      checkOutput("strobes",
                  32'({bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc, bus.ld_ac, bus.ld_pc, bus.wr, bus.data_e}),
                  32'(exp_strobes(m_phase, m_halted, cur_op, cur_zero)));
      checkOutput("phase", 32'(bus.phase), 32'(m_phase));
      checkOutput("flags", 32'({bus.halted, bus.illegal_op, bus.mem_err}), 32'({m_halted, m_ill, m_err}));
   endtask

   // One clock: drive inputs after the falling edge, check, then advance the model across the rising edge.
   task automatic applyStimulus(input logic [3:0] op, input logic z, input logic rdy, input logic res);
      @(negedge clk);
      cur_op      = op;
      cur_zero    = z;
      cur_rdy     = rdy;
      cur_resume  = res;
      bus.opcode  = op;
      bus.zero    = z;
      bus.mem_rdy = rdy;
      bus.resume  = res;
      #1;
      compare_all();
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ = 1'b0;
      #1;
      m_phase  = 0;
      m_halted = 0;
      m_ill    = 0;
      m_err    = 0;
      m_wait   = 0;
      compare_all();
      @(negedge clk);
      #1;
      compare_all();
      rst_ = 1'b1;
      model_step();
   endtask

   task automatic run_instr(input logic [3:0] op, input logic z, input int stall_ph, input int stall_n, input int max_cycles);
      int  stalled;
      int  n;
      bit  done;
      logic rdy;
      stalled = 0;
      n       = 0;
      done    = 0;
      while (!done && (n < max_cycles)) begin
         rdy = 1'b1;
         if ((m_phase == stall_ph) && (stalled < stall_n)) begin
            rdy = 1'b0;
            stalled++;
         end
         applyStimulus(op, z, rdy, 1'b0);
         n++;
         if ((m_phase == 0) || m_halted) done = 1;
      end
      checkOutput("instr_done", 32'(done), 32'(1));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish, limit 2000000 ns");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      logic [3:0] op_sel;
      int         burst_left;
      logic       rdy, res;

      rst_        = 1'b0;
      cur_op      = 4'b0010;
      cur_zero    = 1'b0;
      cur_rdy     = 1'b1;
      cur_resume  = 1'b0;
      bus.opcode  = cur_op;
      bus.zero    = 1'b0;
      bus.mem_rdy = 1'b1;
      bus.resume  = 1'b0;
      do_reset();

      $display("[TB] ADD with memory always ready");
      run_instr(4'b0010, 1'b0, -1, 0, 20);
      run_instr(4'b0010, 1'b1, -1, 0, 20);

      $display("[TB] SKZ with zero set and clear");
      run_instr(4'b0001, 1'b1, -1, 0, 20);
      run_instr(4'b0001, 1'b0, -1, 0, 20);

      $display("[TB] STO with three wait cycles on the write");
      run_instr(4'b0110, 1'b0, 7, 3, 20);
      run_instr(4'b0111, 1'b0, 3, 2, 20);

      $display("[TB] LDA read never completes, watchdog expiry then resume");
      run_instr(4'b0101, 1'b0, 6, 100, 60);
      for (int i = 0; i < 4; i++) applyStimulus(4'b0101, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      applyStimulus(4'b0101, 1'b0, 1'b0, 1'b1);
      run_instr(4'b0011, 1'b0, 6, 14, 40);

      $display("[TB] HLT, frozen for 20 cycles, resume");
      run_instr(4'b0000, 1'b0, -1, 0, 20);
      for (int i = 0; i < 20; i++) applyStimulus(4'b0000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
      run_instr(4'b0000, 1'b0, -1, 0, 20);

      $display("[TB] Illegal opcode trap, reset while halted");
      run_instr(4'b1010, 1'b0, -1, 0, 20);
      for (int i = 0; i < 3; i++) applyStimulus(4'b1010, 1'b0, 1'b1, 1'b0);
      do_reset();

      $display("[TB] Randomized traffic");
      burst_left = 0;
      op_sel     = 4'b0010;
      for (int i = 0; i < 3000; i++) begin
         if ((m_phase == 0) && !m_halted)
            op_sel = {($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7))};
         if (burst_left > 0) begin
            rdy = 1'b0;
            burst_left--;
         end else begin
            if ($urandom_range(0, 49) == 0) burst_left = $urandom_range(10, 20);
            rdy = ($urandom_range(0, 3) != 0);
         end
         if (m_halted) res = ($urandom_range(0, 5) == 0);
         else          res = ($urandom_range(0, 20) == 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         else applyStimulus(op_sel, 1'($urandom_range(0, 1)), rdy, res);
      end
      applyStimulus(op_sel, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end
endmodule
